// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between requester A (datapath)
//   and requester B (debug/loader) with round-robin fairness, one transaction at a time.
// Latency: req sampled in IDLE -> ACCESS next cycle -> one-cycle ack pulse the cycle after
//   (2 cycles from the sampling edge to ack). Alternating A/B: 2 cycles per transaction.
// Backpressure: req/ack handshake; a requester holds req and its command stable until its
//   ack. The losing requester simply waits, and is served right after the winner's transaction.
//
// Ports:
//   CLK, reset               clock (rising edge), asynchronous active-high reset
//   a_req/a_we/a_adrs/a_wd   requester A command (held until a_ack)
//   a_ack/a_rdata            A completion pulse and read data (valid with a_ack)
//   b_*                      same as A, for requester B
//   mem_we/mem_adrs/mem_wd   drive the dMem write enable, address and write data
//   mem_rdata                dMem combinational read data
//   busy                     high whenever a transaction is in flight (not IDLE)

module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          reset,

  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_adrs,
  input  logic [DW-1:0] a_wd,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,

  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_adrs,
  input  logic [DW-1:0] b_wd,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,

  output logic          mem_we,
  output logic [AW-1:0] mem_adrs,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rdata,

  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Requester encoding for gnt/last: 0 = A, 1 = B.
  state_t        state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          last_q, last_d;
  logic          cmd_we_q, cmd_we_d;
  logic [AW-1:0] cmd_adrs_q, cmd_adrs_d;
  logic [DW-1:0] cmd_wd_q, cmd_wd_d;
  logic [DW-1:0] rdata_q, rdata_d;

  // Requests that may win this cycle's arbitration.
  logic elig_a;
  logic elig_b;
  logic pick_b;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    cmd_we_d   = cmd_we_q;
    cmd_adrs_d = cmd_adrs_q;
    cmd_wd_d   = cmd_wd_q;
    rdata_d    = rdata_q;
    elig_a     = 1'b0;
    elig_b     = 1'b0;
    pick_b     = 1'b0;

    case (state_q)
      IDLE: begin
        elig_a = a_req;
        elig_b = b_req;
      end
      ACCESS: begin
        // dMem read is combinational; capture it at the closing edge. On a
        // write this is the pre-write contents, since dMem commits on the same edge.
        rdata_d = mem_rdata;
        state_d = RESP;
      end
      RESP: begin
        // The requester being acked still shows the req of the finished
        // transaction, so only the other side can be granted here.
        elig_a  = a_req & gnt_q;
        elig_b  = b_req & ~gnt_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Single request wins outright; a tie goes to whoever was not served last.
    pick_b = elig_b & (~elig_a | ~last_q);

    if (elig_a | elig_b) begin
      state_d    = ACCESS;
      gnt_d      = pick_b;
      last_d     = pick_b;
      cmd_we_d   = pick_b ? b_we   : a_we;
      cmd_adrs_d = pick_b ? b_adrs : a_adrs;
      cmd_wd_d   = pick_b ? b_wd   : a_wd;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;  // B counts as last served, so A wins the first tie
      cmd_we_q   <= 1'b0;
      cmd_adrs_q <= '0;
      cmd_wd_q   <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      cmd_we_q   <= cmd_we_d;
      cmd_adrs_q <= cmd_adrs_d;
      cmd_wd_q   <= cmd_wd_d;
      rdata_q    <= rdata_d;
    end
  end

  // Write enable is qualified by state so that an asynchronous reset during
  // ACCESS removes it before the closing edge and the write is never committed.
  assign mem_we   = (state_q == ACCESS) & cmd_we_q;
  assign mem_adrs = cmd_adrs_q;
  assign mem_wd   = cmd_wd_q;

  assign a_ack    = (state_q == RESP) & ~gnt_q;
  assign b_ack    = (state_q == RESP) &  gnt_q;
  assign a_rdata  = rdata_q;
  assign b_rdata  = rdata_q;

  assign busy     = (state_q != IDLE);

  ack_exclusive: assert property (@(posedge CLK) disable iff (reset) !(a_ack && b_ack));
  ack_one_cycle: assert property (@(posedge CLK) disable iff (reset)
                                  (a_ack |=> !a_ack) and (b_ack |=> !b_ack));

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port data memory (dMem) between the processor datapath (requester A) and a debug/loader port (requester B). Each requester uses a req/ack handshake. The arbiter picks one transaction at a time with round-robin fairness, drives dMem's WE/adrs/WD from latched command registers, and returns registered read data with a one-cycle ack pulse. It sits between the datapath's load/store path and the dMem instance.

## Interface
- AW, 32, address width (matches dMem adrs)
- DW, 32, data width (matches dMem WD/rData)

- CLK  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- a_req  in  1  requester A transaction request, held until a_ack
- a_we  in  1  A: 1 = write, 0 = read
- a_adrs  in  AW  A byte address
- a_wd  in  DW  A write data
- a_ack  out  1  A completion pulse, one cycle
- a_rdata  out  DW  A read data, valid when a_ack=1
- b_req, b_we, b_adrs, b_wd, b_ack, b_rdata  same as A, for requester B
- mem_we  out  1  to dMem WE
- mem_adrs  out  AW  to dMem adrs
- mem_wd  out  DW  to dMem WD
- mem_rdata  in  DW  from dMem rData (combinational read)
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ACCESS, RESP. Internal registers: gnt (0=A, 1=B), last (last granted requester), cmd_we/cmd_adrs/cmd_wd, rdata_q.
- Arbitration: if exactly one eligible req is high, grant it. If both are high, grant the requester that is not `last`.
- Grant action: latch the winner's we/adrs/wd into cmd_*, set gnt, set last=winner, go to ACCESS.
- IDLE: all requesters are eligible. Any eligible req → ACCESS, otherwise stay in IDLE.
- ACCESS (one cycle): mem_we=cmd_we; mem_adrs=cmd_adrs; mem_wd=cmd_wd. At the closing edge, rdata_q←mem_rdata. dMem performs the write on the same edge. Always go to RESP.
- RESP (one cycle): the ack of the gnt requester is 1. Both *_rdata outputs show rdata_q.
  - Arbitration in RESP excludes the requester being acked, because its req that cycle belongs to the finished transaction.
  - If the other requester's req is high: grant it and go directly to ACCESS.
  - Otherwise go to IDLE.
- A write transaction returns the pre-write contents of the addressed word in rdata. Requesters ignore it.
- mem_we is 0 in every state except ACCESS. mem_adrs and mem_wd hold cmd_* in all states.
- Requester rules:
  - req, we, adrs and wd stay stable from req rise until ack.
  - req may remain high through the ack cycle. Its value on the cycle after ack is treated as a new request, which may carry new command fields.
  - Dropping req before ack is illegal. The arbiter still completes the latched transaction.

## Timing
- Reset values (applied asynchronously): state=IDLE, last=B (so A wins the first tie), gnt=0, cmd_*=0, rdata_q=0.
  - All outputs therefore reset to 0: a_ack, b_ack, mem_we, mem_adrs, mem_wd, a_rdata, b_rdata, busy.
- Latency: a req sampled high in IDLE at edge n puts ACCESS in cycle n..n+1. Ack is high in cycle n+1..n+2. This is 2 cycles from the sampling edge to ack.
- Throughput:
  - Alternating A/B contention: one transaction every 2 cycles (RESP→ACCESS).
  - Same requester back-to-back: every 3 cycles (RESP→IDLE→ACCESS).
- Simultaneous requests: strict alternation. A requester never waits more than one transaction of the other.
- Reset mid-ACCESS: mem_we drops immediately, the write is not committed, no ack is issued, and the transaction is lost. The requester must re-issue it after reset.
- Reset during RESP: the ack is truncated.
- ack is never high for both requesters in the same cycle, and never high for more than one consecutive cycle.

## Test plan
- A write 0x10←0xDEADBEEF, then A read 0x10 → the second a_ack has a_rdata=0xDEADBEEF. mem_we=1 for exactly one cycle, during the first ACCESS.
- a_req and b_req rise together from reset (A: read 0x0; B: write 0x4←0x55) → A is acked first, B is acked 2 cycles later. b_ack never coincides with a_ack.
- Both requesters hold req continuously for 6 transactions → grants alternate A,B,A,B,A,B. Acks arrive every 2 cycles.
- B alone issues 3 back-to-back reads of 0x8, 0xC, 0x10 holding req → b_ack arrives every 3 cycles with the correct data. a_ack stays 0.
- Write 0x20←0x1234 with reset pulsed during ACCESS → no ack, mem_we deasserts asynchronously. A later read of 0x20 returns the old value, not 0x1234. All outputs are 0 during reset.
- Write to 0x24←0x99 → the returned rdata equals the prior contents of 0x24 (pre-write value).
